// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Used by pc_sequencer and pc_perf_cnt.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } pc_seq_state_e;

    localparam int DEFAULT_STEP = 4;

endpackage

// File: rtl/pc_perf_cnt.sv
// Saturating event counter; holds at all-ones and clears only on reset.
// Instantiated by pc_sequencer when PC_SEQ_PERF_EN is defined.
module pc_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: selects the PC input, drives PC/IF-ID enables and flush,
// and buffers a redirect raised during a memory stall. Perf counters under PC_SEQ_PERF_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = DEFAULT_STEP,
    parameter int              CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mem_stall_i,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic [XLEN-1:0]  branch_target_i,
    input  logic [XLEN-1:0]  pc_cur_i,
    output logic [XLEN-1:0]  pc_next_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    pc_seq_state_e   r_state;
    logic            r_pend_vld;
    logic [XLEN-1:0] r_pend_tgt;

    logic w_active;
    logic w_capture;

    // Dropping start_i makes RUN/STALL behave as IDLE within the same cycle.
    assign w_active  = (r_state != IDLE) && start_i;
    assign w_capture = w_active && mem_stall_i && branch_taken_i && !hazard_i && !r_pend_vld;

    always_comb begin
        pc_next_o    = RESET_VECTOR;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b0;
        flush_o      = 1'b1;
        if (w_active) begin
            if (mem_stall_i || hazard_i) begin
                pc_next_o    = pc_cur_i;
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                flush_o      = 1'b0;
            end else if (r_pend_vld) begin
                // Buffered redirect wins; the live branch is the re-presented one.
                pc_next_o    = r_pend_tgt;
            end else if (branch_taken_i) begin
                pc_next_o    = branch_target_i;
            end else begin
                pc_next_o    = pc_cur_i + XLEN'(STEP);
                ifid_write_o = 1'b1;
                flush_o      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
        end else if (!w_active) begin
            r_state    <= (r_state == IDLE && start_i) ? RUN : IDLE;
            r_pend_vld <= 1'b0;
        end else if (mem_stall_i) begin
            r_state <= STALL;
            if (w_capture) begin
                r_pend_vld <= 1'b1;
                r_pend_tgt <= branch_target_i;
            end
        end else begin
            r_state <= RUN;
            // A hazard on the release cycle keeps the redirect parked.
            if (!hazard_i) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic w_stall_inc;
    logic w_redir_inc;

    assign w_stall_inc = w_active && mem_stall_i;
    assign w_redir_inc = w_active && flush_o;

    pc_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt_o)
    );

    pc_perf_cnt #(.CNT_W(CNT_W)) u_redir_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_inc (w_redir_inc),
        .o_cnt (redirect_cnt_o)
    );
`else
    assign stall_cnt_o    = '0;
    assign redirect_cnt_o = '0;
`endif

endmodule
